m68k_bus_ctrl: RTL and testbench
================================

// Module: m68k_bus_ctrl
// PURPOSE
// Parametrised 68000 bus controller replacing fixed glue logic: chip-select decode,
// per-region wait-state DTACK generation, autovectored timer interrupt (IPL/VPA),
// and debounced CPU reset/halt. Sits between the 68000, ROM/RAM and FT245-style serial FIFO.
// Map: 00000-77FFF ROM, 78000-7FFFF device (addr[14:13]: 00 rx, 01 tx, 10 status, 11 ctrl),
// 80000-FFFFF RAM.
// PARAMETERS
// ROM_WAIT      2      wait cycles before _dtack for ROM (0..15)
// RAM_WAIT      0      wait cycles for RAM (0..15)
// IO_WAIT       3      wait cycles for device region (0..15)
// TIMER_DIV     32768  timer tick period in clk cycles (>=2)
// TIMER_IPL     6      IPL level for timer interrupt (1..7)
// DEB_BITS      16     debounce sample period = 2**DEB_BITS clk cycles
// BERR_CYCLES   64     bus-timeout limit (BUS_ERROR_EN only)
// PORTS
// clk        in   1   system clock
// reset      in   1   asynchronous active-high reset
// addr       in   8   CPU A[19:12]
// _as,_ds,rw in   1   68000 strobes / direction
// fc0,fc1    in   1   function code; fc0&fc1 = interrupt acknowledge
// din        in   2   D[1:0] for ctrl writes: bit0 LED, bit1 timer enable
// button     in   1   reset button, active low, bouncy
// _ceram,_cerom out 1 RAM/ROM chip enables, active low
// _oe        out  1   ~rw
// _rd,wr     out  1   serial FIFO read strobe (low) / write strobe (high)
// _dtack,_vpa out 1   cycle termination / autovector request, active low
// _ipl2,_ipl1,_ipl0 out 1 inverted interrupt level
// _cpu_reset out  1   drives _reset and _halt low (open-drain by top level)
// status_led out  1   LED register bit
// _berr      out  1   bus error, active low (tied 1 without BUS_ERROR_EN)
// BEHAVIOUR
// - Reset (async): FSM IDLE, _dtack=_vpa=1, timer_en=0, pending=0, prescaler=0, LED=0,
//   _cpu_reset=0, debounced button=0, _berr=1; all chip enables/strobes inactive.
// - Decode purely combinational, qualified by ~_as & ~iack; strobes as memory-map above;
//   wr additionally needs ~_ds; ctrl write = device, addr[14:13]=11, ~rw, ~_ds.
// - FSM IDLE->WAIT on first clk with ~_as & ~iack: load region wait count. WAIT decrements;
//   at 0 ->ACK (count 0 goes IDLE->ACK directly, _dtack low 1 clk after _as seen).
//   ACK holds _dtack=0 until _as high, then IDLE same edge, _dtack=1.
// - IACK (~_as & fc0&fc1): IDLE->ACK with _vpa=0 instead of _dtack; clears pending on entry.
// - _as rising in WAIT (aborted cycle): return IDLE, no _dtack.
// - Ctrl write latched on the clk where FSM enters ACK; LED<=din[0], timer_en<=din[1];
//   timer_en 1->0 also clears pending and prescaler.
// - Timer: prescaler counts 0..TIMER_DIV-1 while timer_en, wraps, sets pending at wrap.
//   Tick coinciding with IACK entry: set wins (new interrupt not lost).
// - {_ipl2,_ipl1,_ipl0} = pending ? ~TIMER_IPL : 3'b111, registered.
// - Reset ctl: button sampled when free-running DEB_BITS counter wraps to 0;
//   _cpu_reset = debounced button, so low >= one sample period after reset release.
// CONFIGURATION
// BUS_ERROR_EN defined: counter runs while FSM in WAIT/ACK-wait or ~_as with no region/
//   IACK match; on reaching BERR_CYCLES assert _berr=0 until _as high, FSM -> IDLE.
// BUS_ERROR_EN undefined: no counter, _berr constant 1, unmapped cycles hang (legacy).
// TESTING
// - ROM read @0x01000, ROM_WAIT=2: _as low -> _dtack low exactly 3 clks later, _cerom=0,
//   _dtack high 1 clk after _as rises.
// - RAM read @0x80000, RAM_WAIT=0: _dtack low 1 clk after _as; _ceram=0, _cerom=1.
// - Ctrl write din=2'b11 @0x7E000: status_led=1, timer_en=1; TIMER_DIV=8 -> IPL=~6
//   8 clks later; IACK cycle -> _vpa=0, _dtack=1, IPL returns 3'b111.
// - Serial: read @0x78000 -> _rd=0 only while ~_as; write @0x7A000 -> wr=1 only with ~_ds.
// - Reset: assert reset mid-WAIT -> _dtack=1, FSM IDLE, _cpu_reset=0 immediately;
//   button held 1 -> _cpu_reset=1 at first DEB counter wrap.
// - BUS_ERROR_EN, BERR_CYCLES=64: IACK-less unmapped cycle held -> _berr=0 at clk 64.

Source files
------------

// File: rtl/m68k_bus_ctrl_if.sv
// rtl/m68k_bus_ctrl_if.sv - 68000 bus signal bundle between the CPU side and the bus controller
interface m68k_bus_ctrl_if;
  logic [7:0] addr;
  logic       _as, _ds, rw, fc0, fc1;
  logic [1:0] din;
  logic       _ceram, _cerom, _oe, _rd, wr;
  logic       _dtack, _vpa, _ipl2, _ipl1, _ipl0, _berr;

  modport master (
    output addr, _as, _ds, rw, fc0, fc1, din,
    input  _ceram, _cerom, _oe, _rd, wr, _dtack, _vpa, _ipl2, _ipl1, _ipl0, _berr
  );

  modport slave (
    input  addr, _as, _ds, rw, fc0, fc1, din,
    output _ceram, _cerom, _oe, _rd, wr, _dtack, _vpa, _ipl2, _ipl1, _ipl0, _berr
  );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// rtl/m68k_bus_ctrl.sv - 68000 glue: decode, wait-state DTACK, autovectored timer IRQ, reset debounce
// Optional bus-timeout / _berr generation enabled by defining BUS_ERROR_EN.
module m68k_bus_ctrl #(
  parameter int unsigned ROM_WAIT    = 2,
  parameter int unsigned RAM_WAIT    = 0,
  parameter int unsigned IO_WAIT     = 3,
  parameter int unsigned TIMER_DIV   = 32768,
  parameter int unsigned TIMER_IPL   = 6,
  parameter int unsigned DEB_BITS    = 16,
  parameter int unsigned BERR_CYCLES = 64
) (
  input  logic           clk,
  input  logic           reset,
  m68k_bus_ctrl_if.slave bus,
  input  logic           button,
  output logic           _cpu_reset,
  output logic           status_led
);
  localparam int unsigned      PRE_W      = $clog2(TIMER_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TIMER_DIV - 1);
  localparam logic [2:0]       IPL_ACTIVE = ~3'(TIMER_IPL);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t           state;
  logic [3:0]       wait_cnt, wait_cycles;
  logic             dtack, vpa, led, timer_en, pending, pending_next;
  logic [PRE_W-1:0] prescaler;
  logic [2:0]       ipl_n;
  logic             iack, cycle, rom_sel, ram_sel, dev_sel, ctrl_wr;
  logic             start, iack_take, enter_ack, ctrl_latch, tick, timer_off;
  logic             berr_hit, bus_free;
  logic [DEB_BITS-1:0] deb_cnt;
  logic             deb;

  assign iack    = bus.fc0 & bus.fc1;
  assign cycle   = ~bus._as & ~iack;
  assign rom_sel = bus.addr < 8'h78;
  assign ram_sel = bus.addr[7];
  assign dev_sel = ~rom_sel & ~ram_sel;
  assign ctrl_wr = cycle & dev_sel & (bus.addr[2:1] == 2'b11) & ~bus.rw & ~bus._ds;

  assign bus._cerom = ~(cycle & rom_sel);
  assign bus._ceram = ~(cycle & ram_sel);
  assign bus._rd    = ~(cycle & dev_sel & (bus.addr[2:1] == 2'b00) & bus.rw);
  assign bus.wr     = cycle & dev_sel & (bus.addr[2:1] == 2'b01) & ~bus.rw & ~bus._ds;
  assign bus._oe    = ~bus.rw;

  assign wait_cycles = rom_sel ? 4'(ROM_WAIT) : (ram_sel ? 4'(RAM_WAIT) : 4'(IO_WAIT));

  assign start      = (state == IDLE) & bus_free & cycle;
  assign iack_take  = (state == IDLE) & bus_free & ~bus._as & iack;
  assign enter_ack  = (start & (wait_cycles == 4'd0)) |
                      ((state == WAIT) & ~bus._as & ~berr_hit & (wait_cnt == 4'd0));
  assign ctrl_latch = enter_ack & ctrl_wr;
  assign tick       = timer_en & (prescaler == PRE_LAST);
  assign timer_off  = ctrl_latch & ~bus.din[1];

  // A tick on the same edge as the acknowledge re-arms, so no interrupt is lost.
  always_comb begin
    pending_next = pending;
    if (timer_off)      pending_next = 1'b0;
    else if (tick)      pending_next = 1'b1;
    else if (iack_take) pending_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      dtack     <= 1'b1;
      vpa       <= 1'b1;
      led       <= 1'b0;
      timer_en  <= 1'b0;
      pending   <= 1'b0;
      prescaler <= '0;
      ipl_n     <= 3'b111;
    end else begin
      case (state)
        IDLE: begin
          if (iack_take) begin
            state <= ACK;
            vpa   <= 1'b0;
          end else if (start) begin
            if (wait_cycles == 4'd0) begin
              state <= ACK;
              dtack <= 1'b0;
            end else begin
              state    <= WAIT;
              wait_cnt <= wait_cycles - 4'd1;
            end
          end
        end
        WAIT: begin
          if (bus._as || berr_hit) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ACK;
            dtack <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK: begin
          if (bus._as || berr_hit) begin
            state <= IDLE;
            dtack <= 1'b1;
            vpa   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (ctrl_latch) begin
        led      <= bus.din[0];
        timer_en <= bus.din[1];
      end
      if (timer_off)     prescaler <= '0;
      else if (timer_en) prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      pending <= pending_next;
      ipl_n   <= pending_next ? IPL_ACTIVE : 3'b111;
    end
  end

`ifdef BUS_ERROR_EN
  localparam int unsigned BERR_W = $clog2(BERR_CYCLES + 1);
  logic [BERR_W-1:0] berr_cnt;
  logic              berr_n;

  // Any strobe held this long without release is treated as a dead cycle.
  assign berr_hit = ~bus._as & berr_n & (berr_cnt == BERR_W'(BERR_CYCLES - 1));
  assign bus_free = berr_n & ~berr_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      berr_cnt <= '0;
      berr_n   <= 1'b1;
    end else if (bus._as) begin
      berr_cnt <= '0;
      berr_n   <= 1'b1;
    end else if (berr_n) begin
      berr_cnt <= berr_cnt + BERR_W'(1);
      if (berr_hit) berr_n <= 1'b0;
    end
  end
  assign bus._berr = berr_n;
`else
  assign berr_hit  = 1'b0;
  assign bus_free  = 1'b1;
  assign bus._berr = 1'b1;
`endif

  // Button is only looked at once per sample period, which swallows contact bounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      deb     <= 1'b0;
    end else begin
      deb_cnt <= deb_cnt + DEB_BITS'(1);
      if (&deb_cnt) deb <= button;
    end
  end

  assign _cpu_reset = deb;
  assign status_led = led;
  assign bus._dtack = dtack;
  assign bus._vpa   = vpa;
  assign {bus._ipl2, bus._ipl1, bus._ipl0} = ipl_n;
endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// tb/tb_m68k_bus_ctrl.sv - self-checking bench for m68k_bus_ctrl with randomized bus cycles
`timescale 1ns/1ps
module tb_m68k_bus_ctrl;
  localparam int ROM_W = 2, RAM_W = 0, IO_W = 3, DIV = 8, IPL = 6, DEB = 4, BERR = 64;
  localparam int DEB_PERIOD = 1 << DEB;

  typedef struct {
    int   lat;
    int   ack_at;
    logic cerom, ceram, rd_n, oe_n, wr_nods, wr_ds;
    logic dtack_hold, vpa_hold;
    logic cerom_off, ceram_off, rd_off, wr_off, dtack_end;
  } obs_t;

  logic clk = 1'b0;
  logic reset, button, cpu_reset_n, led;
  logic [2:0] ipl;
  int cyc = 0;
  int rel_cyc = 0;
  int total = 0;
  int passed = 0;

  m68k_bus_ctrl_if bus_if ();

  m68k_bus_ctrl #(
    .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .TIMER_DIV(DIV),
    .TIMER_IPL(IPL), .DEB_BITS(DEB), .BERR_CYCLES(BERR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .button(button),
    ._cpu_reset(cpu_reset_n),
    .status_led(led)
  );

  assign ipl = {bus_if._ipl2, bus_if._ipl1, bus_if._ipl0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // 0 = ROM, 1 = device, 2 = RAM, from the full 20-bit address
  function automatic int region_of(input logic [7:0] a);
    int full;
    full = int'(a) * 4096;
    if (full < 32'h78000) return 0;
    if (full < 32'h80000) return 1;
    return 2;
  endfunction

  function automatic int wait_of(input logic [7:0] a);
    case (region_of(a))
      0:       return ROM_W;
      1:       return IO_W;
      default: return RAM_W;
    endcase
  endfunction

  function automatic int dev_sub(input logic [7:0] a);
    return ((int'(a) * 4096) >> 13) & 3;
  endfunction

  task automatic bus_idle();
    bus_if.addr = 8'h00; bus_if._as = 1'b1; bus_if._ds = 1'b1; bus_if.rw = 1'b1;
    bus_if.fc0 = 1'b0; bus_if.fc1 = 1'b0; bus_if.din = 2'b00;
  endtask

  task automatic run_cycle(input logic [7:0] a, input logic r, input logic [1:0] d,
                           input int hold, output obs_t o);
    @(negedge clk);
    bus_if.addr = a; bus_if.rw = r; bus_if.din = d; bus_if.fc0 = 1'b0; bus_if.fc1 = 1'b0;
    bus_if._ds = 1'b1; bus_if._as = 1'b0;
    #1;
    o.cerom = bus_if._cerom; o.ceram = bus_if._ceram; o.rd_n = bus_if._rd;
    o.oe_n = bus_if._oe; o.wr_nods = bus_if.wr;
    bus_if._ds = 1'b0;
    #1;
    o.wr_ds = bus_if.wr;
    o.lat = 0;
    while (bus_if._dtack !== 1'b0 && o.lat < 40) begin
      @(negedge clk);
      o.lat++;
    end
    o.ack_at = cyc;
    repeat (hold) @(negedge clk);
    o.dtack_hold = bus_if._dtack; o.vpa_hold = bus_if._vpa;
    bus_if._as = 1'b1; bus_if._ds = 1'b1;
    #1;
    o.cerom_off = bus_if._cerom; o.ceram_off = bus_if._ceram;
    o.rd_off = bus_if._rd; o.wr_off = bus_if.wr;
    @(negedge clk);
    o.dtack_end = bus_if._dtack;
  endtask

  task automatic test_reset();
    int k;
    reset = 1'b1; button = 1'b1; bus_idle();
    repeat (3) @(negedge clk);
    total++; if (bus_if._dtack !== 1'b1) $display("FAIL rst_dtack got=%b want=1", bus_if._dtack); else passed++;
    total++; if (bus_if._vpa !== 1'b1) $display("FAIL rst_vpa got=%b want=1", bus_if._vpa); else passed++;
    total++; if (ipl !== 3'b111) $display("FAIL rst_ipl got=%b want=111", ipl); else passed++;
    total++; if (led !== 1'b0) $display("FAIL rst_led got=%b want=0", led); else passed++;
    total++; if (cpu_reset_n !== 1'b0) $display("FAIL rst_cpu_reset got=%b want=0", cpu_reset_n); else passed++;
    total++; if (bus_if._berr !== 1'b1) $display("FAIL rst_berr got=%b want=1", bus_if._berr); else passed++;
    total++; if ({bus_if._cerom, bus_if._ceram, bus_if._rd, bus_if.wr} !== 4'b1110)
      $display("FAIL rst_strobes got=%b want=1110", {bus_if._cerom, bus_if._ceram, bus_if._rd, bus_if.wr}); else passed++;
    reset = 1'b0; rel_cyc = cyc;
    k = 0;
    while (cpu_reset_n !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== DEB_PERIOD) $display("FAIL deb_release got=%0d want=%0d", k, DEB_PERIOD); else passed++;
  endtask

  task automatic test_rom();
    obs_t o;
    run_cycle(8'h01, 1'b1, 2'b00, 2, o);
    total++; if (o.lat !== ROM_W + 1) $display("FAIL rom_latency got=%0d want=%0d", o.lat, ROM_W + 1); else passed++;
    total++; if ({o.cerom, o.ceram} !== 2'b01) $display("FAIL rom_ce got=%b want=01", {o.cerom, o.ceram}); else passed++;
    total++; if (o.dtack_hold !== 1'b0) $display("FAIL rom_dtack_hold got=%b want=0", o.dtack_hold); else passed++;
    total++; if (o.dtack_end !== 1'b1) $display("FAIL rom_dtack_end got=%b want=1", o.dtack_end); else passed++;
  endtask

  task automatic test_ram();
    obs_t o;
    run_cycle(8'h80, 1'b1, 2'b00, 1, o);
    total++; if (o.lat !== RAM_W + 1) $display("FAIL ram_latency got=%0d want=%0d", o.lat, RAM_W + 1); else passed++;
    total++; if ({o.cerom, o.ceram} !== 2'b10) $display("FAIL ram_ce got=%b want=10", {o.cerom, o.ceram}); else passed++;
    total++; if (o.dtack_end !== 1'b1) $display("FAIL ram_dtack_end got=%b want=1", o.dtack_end); else passed++;
  endtask

  task automatic test_serial();
    obs_t o;
    run_cycle(8'h78, 1'b1, 2'b00, 0, o);
    total++; if ({o.rd_n, o.rd_off} !== 2'b01) $display("FAIL ser_rd got=%b want=01", {o.rd_n, o.rd_off}); else passed++;
    total++; if (o.lat !== IO_W + 1) $display("FAIL ser_rd_latency got=%0d want=%0d", o.lat, IO_W + 1); else passed++;
    run_cycle(8'h7A, 1'b0, 2'b00, 0, o);
    total++; if ({o.wr_nods, o.wr_ds, o.wr_off} !== 3'b010)
      $display("FAIL ser_wr got=%b want=010", {o.wr_nods, o.wr_ds, o.wr_off}); else passed++;
    total++; if (o.rd_n !== 1'b1) $display("FAIL ser_wr_rd got=%b want=1", o.rd_n); else passed++;
  endtask

  task automatic test_random_cycles();
    obs_t o;
    logic [7:0] a;
    logic r;
    int rg, sub, bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 255));
      r = 1'($urandom_range(0, 1));
      rg = region_of(a); sub = dev_sub(a);
      if (rg == 1 && sub == 3) r = 1'b1;
      run_cycle(a, r, 2'($urandom_range(0, 3)), $urandom_range(0, 3), o);
      total++; if (o.lat !== wait_of(a) + 1)
        $display("FAIL rnd_latency addr=%h got=%0d want=%0d", a, o.lat, wait_of(a) + 1); else passed++;
      total++; if ({o.cerom, o.ceram} !== {rg != 0, rg != 2})
        $display("FAIL rnd_ce addr=%h got=%b want=%b", a, {o.cerom, o.ceram}, {rg != 0, rg != 2}); else passed++;
      total++; if ({o.rd_n, o.wr_ds} !== {!(rg == 1 && sub == 0 && r), rg == 1 && sub == 1 && !r})
        $display("FAIL rnd_serial addr=%h rw=%b got=%b", a, r, {o.rd_n, o.wr_ds}); else passed++;
      total++; if (o.oe_n !== ~r) $display("FAIL rnd_oe got=%b want=%b", o.oe_n, ~r); else passed++;
      if (o.wr_nods !== 1'b0 || o.dtack_hold !== 1'b0 || o.vpa_hold !== 1'b1 || o.dtack_end !== 1'b1 ||
          {o.cerom_off, o.ceram_off, o.rd_off, o.wr_off} !== 4'b1110 || bus_if._berr !== 1'b1) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rnd_protocol got=%0d bad cycles want=0", bad); else passed++;
  endtask

  task automatic test_timer();
    obs_t o;
    int en_at, k;
    run_cycle(8'h7E, 1'b0, 2'b11, 0, o);
    en_at = o.ack_at;
    total++; if (led !== 1'b1) $display("FAIL tmr_led got=%b want=1", led); else passed++;
    k = 0;
    while (ipl === 3'b111 && k < 50) begin @(negedge clk); k++; end
    total++; if (cyc - en_at !== DIV) $display("FAIL tmr_first_tick got=%0d want=%0d", cyc - en_at, DIV); else passed++;
    total++; if (ipl !== ~3'(IPL)) $display("FAIL tmr_ipl got=%b want=%b", ipl, ~3'(IPL)); else passed++;
    bus_if.fc0 = 1'b1; bus_if.fc1 = 1'b1; bus_if._as = 1'b0; bus_if._ds = 1'b0;
    @(negedge clk);
    total++; if ({bus_if._vpa, bus_if._dtack} !== 2'b01)
      $display("FAIL iack_vpa got=%b want=01", {bus_if._vpa, bus_if._dtack}); else passed++;
    total++; if (ipl !== 3'b111) $display("FAIL iack_ipl_clear got=%b want=111", ipl); else passed++;
    bus_if._as = 1'b1; bus_if._ds = 1'b1;
    @(negedge clk);
    total++; if (bus_if._vpa !== 1'b1) $display("FAIL iack_vpa_end got=%b want=1", bus_if._vpa); else passed++;
    k = 0;
    while (ipl === 3'b111 && k < 50) begin @(negedge clk); k++; end
    total++; if (cyc - en_at !== 2 * DIV) $display("FAIL tmr_second_tick got=%0d want=%0d", cyc - en_at, 2 * DIV); else passed++;
    // acknowledge lands on the very edge of the next tick
    while (cyc < en_at + 3 * DIV - 1) @(negedge clk);
    bus_if._as = 1'b0; bus_if._ds = 1'b0;
    @(negedge clk);
    total++; if ({bus_if._vpa, ipl} !== {1'b0, ~3'(IPL)})
      $display("FAIL iack_tick_collide got=%b want=%b", {bus_if._vpa, ipl}, {1'b0, ~3'(IPL)}); else passed++;
    bus_if._as = 1'b1; bus_if._ds = 1'b1;
    @(negedge clk);
    bus_if._as = 1'b0; bus_if._ds = 1'b0;
    @(negedge clk);
    total++; if (ipl !== 3'b111) $display("FAIL iack_second_clear got=%b want=111", ipl); else passed++;
    bus_idle();
  endtask

  task automatic test_timer_disable();
    obs_t o;
    int en_at, k, low_seen;
    run_cycle(8'h7E, 1'b0, 2'b00, 0, o);
    total++; if (led !== 1'b0) $display("FAIL dis_led got=%b want=0", led); else passed++;
    low_seen = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (ipl !== 3'b111) low_seen++;
    end
    total++; if (low_seen !== 0) $display("FAIL dis_no_irq got=%0d want=0", low_seen); else passed++;
    run_cycle(8'h7E, 1'b0, 2'b10, 0, o);
    en_at = o.ack_at;
    k = 0;
    while (ipl === 3'b111 && k < 50) begin @(negedge clk); k++; end
    total++; if (cyc - en_at !== DIV) $display("FAIL reen_tick got=%0d want=%0d", cyc - en_at, DIV); else passed++;
    total++; if (led !== 1'b0) $display("FAIL reen_led got=%b want=0", led); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    run_cycle(8'h7E, 1'b0, 2'b01, 0, o);
    total++; if (led !== 1'b1) $display("FAIL mid_led_set got=%b want=1", led); else passed++;
    @(negedge clk);
    bus_if.addr = 8'h01; bus_if.rw = 1'b1; bus_if._as = 1'b0; bus_if._ds = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if ({bus_if._dtack, cpu_reset_n, led, ipl} !== {1'b1, 1'b0, 1'b0, 3'b111})
      $display("FAIL mid_reset got=%b want=100111", {bus_if._dtack, cpu_reset_n, led, ipl}); else passed++;
    bus_idle();
    @(negedge clk);
    reset = 1'b0; rel_cyc = cyc;
    run_cycle(8'h01, 1'b1, 2'b00, 0, o);
    total++; if (o.lat !== ROM_W + 1) $display("FAIL mid_after_latency got=%0d want=%0d", o.lat, ROM_W + 1); else passed++;
    while (cyc < rel_cyc + DEB_PERIOD - 1) @(negedge clk);
    total++; if (cpu_reset_n !== 1'b0) $display("FAIL mid_deb_early got=%b want=0", cpu_reset_n); else passed++;
    @(negedge clk);
    total++; if (cpu_reset_n !== 1'b1) $display("FAIL mid_deb_wrap got=%b want=1", cpu_reset_n); else passed++;
  endtask

  task automatic test_button();
    int k, want;
    for (int p = 0; p < 2; p++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      button = (p == 1);
      want = DEB_PERIOD - ((cyc - rel_cyc) % DEB_PERIOD);
      k = 0;
      while (cpu_reset_n !== button && k < 3 * DEB_PERIOD) begin @(negedge clk); k++; end
      total++; if (k !== want) $display("FAIL button_%0d got=%0d want=%0d", p, k, want); else passed++;
    end
  endtask

`ifdef BUS_ERROR_EN
  task automatic test_berr();
    int k;
    @(negedge clk);
    bus_if.addr = 8'h80; bus_if.rw = 1'b1; bus_if._as = 1'b0; bus_if._ds = 1'b0;
    k = 0;
    while (bus_if._berr !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    total++; if (k !== BERR) $display("FAIL berr_time got=%0d want=%0d", k, BERR); else passed++;
    total++; if (bus_if._dtack !== 1'b1) $display("FAIL berr_dtack got=%b want=1", bus_if._dtack); else passed++;
    bus_idle();
    @(negedge clk);
    total++; if (bus_if._berr !== 1'b1) $display("FAIL berr_release got=%b want=1", bus_if._berr); else passed++;
  endtask
`endif

  initial begin
    bus_idle();
    reset = 1'b1;
    button = 1'b1;
    test_reset();
    test_rom();
    test_ram();
    test_serial();
    test_random_cycles();
    test_timer();
    test_timer_disable();
    test_reset_mid_wait();
    test_button();
`ifdef BUS_ERROR_EN
    test_berr();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
